// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types and constants for the AD7324 conversion sequencer.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [1:0] CH_VO   = 2'd0;
  localparam logic [1:0] CH_TEMP = 2'd1;
  localparam logic [1:0] CH_I    = 2'd2;
  localparam logic [1:0] CH_VIN  = 2'd3;

  localparam int ADDR_HI  = 14;
  localparam int ADDR_LO  = 13;
  localparam int SAMPLE_W = 13;

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way round-robin arbiter with a priority-channel override.
module rr_arb4 (
  input  logic [3:0] pending,
  input  logic [1:0] last_ch,
  input  logic [1:0] prio_ch,
  output logic [1:0] grant_ch,
  output logic       grant_vld
);

  always_comb begin
    grant_ch  = 2'd0;
    grant_vld = 1'b0;
    if (pending[prio_ch]) begin
      grant_ch  = prio_ch;
      grant_vld = 1'b1;
    end else begin
      // Walk farthest-first so the nearest channel after last_ch is the final winner.
      for (int i = 4; i >= 1; i--) begin
        if (pending[last_ch + 2'(i)]) begin
          grant_ch  = last_ch + 2'(i);
          grant_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - schedules AD7324 conversions over vo/temp/i/vin and publishes results.
// Optional ADC_AVG_EN: publish the truncated mean of 2^AVG_LOG2 matching samples per channel.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned TIMEOUT  = 64
`ifdef ADC_AVG_EN
  ,
  parameter int unsigned AVG_LOG2 = 2
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [3:0]          req,
  input  logic [1:0]          prio_ch,
  output logic                conv_start,
  output logic [1:0]          conv_ch,
  input  logic                conv_done,
  input  logic [15:0]         conv_data,
  output logic [SAMPLE_W-1:0] res_vo,
  output logic [SAMPLE_W-1:0] res_temp,
  output logic [SAMPLE_W-1:0] res_i,
  output logic [SAMPLE_W-1:0] res_vin,
  output logic [3:0]          res_valid,
  output logic                busy,
  output logic                timeout_err,
  output logic                addr_err,
  input  logic                err_clr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  logic [3:0]          pending;
  logic [1:0]          last_ch;
  logic [1:0]          grant_ch;
  logic                grant_vld;
  logic                issue_go;
  logic                scan_tick;
  logic [31:0]         scan_cnt;
  logic [TW-1:0]       timer;
  logic [14:0]         data_q;
  logic [SAMPLE_W-1:0] res [4];

`ifdef ADC_AVG_EN
  localparam int AW = SAMPLE_W + AVG_LOG2;
  logic [AW-1:0]       acc [4];
  logic [AVG_LOG2-1:0] cnt [4];
  logic [AW-1:0]       avg_sum;
  assign avg_sum = acc[conv_ch] + AW'(data_q[SAMPLE_W-1:0]);
`endif

  rr_arb4 u_arb (
    .pending   (pending),
    .last_ch   (last_ch),
    .prio_ch   (prio_ch),
    .grant_ch  (grant_ch),
    .grant_vld (grant_vld)
  );

  assign issue_go  = (state == S_IDLE) && enable && grant_vld;
  assign scan_tick = enable && (SCAN_DIV != 0) && (scan_cnt == SCAN_DIV - 1);

  assign res_vo   = res[CH_VO];
  assign res_temp = res[CH_TEMP];
  assign res_i    = res[CH_I];
  assign res_vin  = res[CH_VIN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (!enable || scan_tick) begin
      scan_cnt <= '0;
    end else if (SCAN_DIV != 0) begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end

  // A new request on the bit being issued survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~(issue_go ? (4'b0001 << grant_ch) : 4'b0000))
                 | req | {4{scan_tick}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      conv_start  <= 1'b0;
      conv_ch     <= '0;
      last_ch     <= CH_VIN;
      timer       <= '0;
      data_q      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      addr_err    <= 1'b0;
      res_valid   <= '0;
      for (int c = 0; c < 4; c++) begin
        res[c] <= '0;
`ifdef ADC_AVG_EN
        acc[c] <= '0;
        cnt[c] <= '0;
`endif
      end
    end else begin
      res_valid <= '0;
      if (err_clr) begin
        timeout_err <= 1'b0;
        addr_err    <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (issue_go) begin
            conv_ch    <= grant_ch;
            conv_start <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          conv_start <= 1'b0;
          last_ch    <= conv_ch;
          timer      <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done) begin
            data_q <= conv_data[14:0];
            state  <= S_CAPTURE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (data_q[ADDR_HI:ADDR_LO] == conv_ch) begin
`ifdef ADC_AVG_EN
            if (cnt[conv_ch] == '1) begin
              res[conv_ch]       <= avg_sum[AW-1:AVG_LOG2];
              res_valid[conv_ch] <= 1'b1;
              acc[conv_ch]       <= '0;
              cnt[conv_ch]       <= '0;
            end else begin
              acc[conv_ch] <= avg_sum;
              cnt[conv_ch] <= cnt[conv_ch] + 1'b1;
            end
`else
            res[conv_ch]       <= data_q[SAMPLE_W-1:0];
            res_valid[conv_ch] <= 1'b1;
`endif
          end else begin
            addr_err <= 1'b1;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
